// File: rtl/fusion_pkg.sv
// Shared definitions for the fusion-unit operand path: element width codes,
// word geometry and the width-code decode helpers.
package fusion_pkg;

  localparam int WORD_W = 32;
  localparam int GROUPS = 4;

  // Element width selector as held inside the packer
  typedef enum logic [1:0] {
    WC_2B = 2'd0,
    WC_4B = 2'd1,
    WC_8B = 2'd2
  } width_code_e;

  // Packer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } pack_state_e;

  // Raw 3-bit configuration code to width code; codes above 2 mean 8-bit
  function automatic width_code_e decode_width(input logic [2:0] code);
    case (code)
      3'd0:    return WC_2B;
      3'd1:    return WC_4B;
      default: return WC_8B;
    endcase
  endfunction

  // Element width W in bits
  function automatic logic [3:0] code_to_w(input width_code_e wc);
    case (wc)
      WC_2B:   return 4'd2;
      WC_4B:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Elements per word N = WORD_W / W
  function automatic logic [4:0] code_to_n(input width_code_e wc);
    case (wc)
      WC_2B:   return 5'd16;
      WC_4B:   return 5'd8;
      default: return 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/elem_clamp.sv
// Reduces an 8-bit input element to the configured element width.
// Default build truncates to the low W bits; defining PACKER_SAT_EN
// saturates to the W-bit range (signed or unsigned) instead.
// Result is zero-extended to 8 bits so it can be OR-ed into a word.
module elem_clamp
  import fusion_pkg::*;
(
  input  logic [1:0] wcode,
  input  logic       is_signed,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  width_code_e wcode_s;
  logic [3:0]  w_s;
  logic [7:0]  mask_s;

  assign wcode_s = width_code_e'(wcode);
  assign w_s     = code_to_w(wcode_s);
  assign mask_s  = 8'((9'd1 << w_s) - 9'd1);

`ifdef PACKER_SAT_EN

  // Saturate the element to the selected width's representable range
  always_comb begin
    dout = din & mask_s;
    if (is_signed) begin
      case (wcode_s)
        WC_2B: begin
          if ($signed(din) > 8'sd1)       dout = 8'h01;
          else if ($signed(din) < -8'sd2) dout = 8'h02;
          else                            dout = din & 8'h03;
        end
        WC_4B: begin
          if ($signed(din) > 8'sd7)       dout = 8'h07;
          else if ($signed(din) < -8'sd8) dout = 8'h08;
          else                            dout = din & 8'h0F;
        end
        WC_8B:   dout = din;
        default: dout = din;
      endcase
    end else begin
      case (wcode_s)
        WC_2B: begin
          if (din > 8'd3) dout = 8'h03;
          else            dout = din & 8'h03;
        end
        WC_4B: begin
          if (din > 8'd15) dout = 8'h0F;
          else             dout = din & 8'h0F;
        end
        WC_8B:   dout = din;
        default: dout = din;
      endcase
    end
  end

`else

  // Signedness does not matter when simply dropping the high bits
  logic unused_sign_s;
  assign unused_sign_s = is_signed;

  // Keep only the low W bits of the element
  always_comb begin
    dout = din & mask_s;
  end

`endif

endmodule

// File: rtl/operand_packer.sv
// Packs a stream of 2/4/8-bit elements LSB-first into 32-bit operand words
// for the fusion unit, with per-group sign flags and vector-end marking.
// Optional build macro: PACKER_SAT_EN (saturate instead of truncate).
module operand_packer
  import fusion_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic [2:0]  cfg_bitwidth,
  input  logic        cfg_signed,
  input  logic        cfg_load,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_sign,
  output logic        out_last
);

  pack_state_e state_r;
  pack_state_e state_nxt_s;

  width_code_e wcode_r;
  width_code_e wcode_eff_s;
  logic        signed_r;
  logic        signed_eff_s;

  logic [4:0]  count_r;
  logic [31:0] data_r;

  logic [31:0] out_word_r;
  logic [3:0]  out_sign_r;
  logic        out_last_r;
  logic        out_valid_r;

  logic        accept_s;
  logic        fire_s;
  logic        close_s;
  logic [4:0]  count_inc_s;
  logic [4:0]  n_s;
  logic [4:0]  shamt_s;
  logic [7:0]  elem_s;
  logic [31:0] merged_s;

  // A load in IDLE takes effect for an element accepted in that same cycle
  always_comb begin
    if ((state_r == ST_IDLE) && cfg_load) begin
      wcode_eff_s  = decode_width(cfg_bitwidth);
      signed_eff_s = cfg_signed;
    end else begin
      wcode_eff_s  = wcode_r;
      signed_eff_s = signed_r;
    end
  end

  // In HOLD an element is only taken when the held word leaves the same cycle
  assign in_ready = nRST & ((state_r != ST_HOLD) | out_ready);
  assign accept_s = in_valid & in_ready;
  assign fire_s   = out_valid_r & out_ready;

  elem_clamp u_elem_clamp (
    .wcode     (wcode_eff_s),
    .is_signed (signed_eff_s),
    .din       (in_data),
    .dout      (elem_s)
  );

  // Bit offset of the current slot: count * W
  always_comb begin
    case (wcode_eff_s)
      WC_2B:   shamt_s = {count_r[3:0], 1'b0};
      WC_4B:   shamt_s = {count_r[2:0], 2'b00};
      WC_8B:   shamt_s = {count_r[1:0], 3'b000};
      default: shamt_s = {count_r[1:0], 3'b000};
    endcase
  end

  // The accumulator is always clear in HOLD, so a restart lands at slot 0
  assign merged_s    = data_r | ({24'd0, elem_s} << shamt_s);
  assign n_s         = code_to_n(wcode_eff_s);
  assign count_inc_s = count_r + 5'd1;
  assign close_s     = in_last | (count_inc_s == n_s);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_FILL: begin
        if (accept_s) begin
          state_nxt_s = close_s ? ST_HOLD : ST_FILL;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_nxt_s = close_s ? ST_HOLD : ST_FILL;
        end else if (fire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Configuration, accumulator and registered output word
  always_ff @(posedge clk) begin
    if (!nRST) begin
      wcode_r     <= WC_2B;
      signed_r    <= 1'b0;
      count_r     <= 5'd0;
      data_r      <= 32'd0;
      out_word_r  <= 32'd0;
      out_sign_r  <= 4'd0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      wcode_r  <= wcode_eff_s;
      signed_r <= signed_eff_s;
      if (accept_s && close_s) begin
        out_word_r  <= merged_s;
        out_sign_r  <= {GROUPS{signed_eff_s}};
        out_last_r  <= in_last;
        out_valid_r <= 1'b1;
        data_r      <= 32'd0;
        count_r     <= 5'd0;
      end else if (accept_s) begin
        data_r  <= merged_s;
        count_r <= count_inc_s;
        if (fire_s) begin
          out_valid_r <= 1'b0;
        end else begin
          out_valid_r <= out_valid_r;
        end
      end else if (fire_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_word  = out_word_r;
  assign out_sign  = out_sign_r;
  assign out_last  = out_last_r;

endmodule
